pending_encoder_8to3: RTL

Sequential 8-to-3 encoder that captures up to eight request lines into a pending register and presents one request at a time as a 3-bit index. Each index is held under a valid/ack handshake. It is the encoding counterpart of the team's 3-to-8 enable decoder: a consumer can feed the returned index straight into that decoder to regenerate a one-hot select. It sits between asynchronous-to-the-consumer event sources (interrupt-style pulses) and a single serial consumer.

---
 rtl/pending_encoder_8to3_pkg.sv | 19 +
 rtl/priority_select_8to3.sv | 30 +++
 rtl/pending_encoder_8to3.sv | 87 ++++++++
 3 files changed

// File: rtl/pending_encoder_8to3_pkg.sv
// Shared sizes, FSM encoding and helpers for the 8-to-3 pending encoder.
package pending_encoder_8to3_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/priority_select_8to3.sv
// Combinational circular priority selector: first set request scanning from
// an offset, upward, or downward from index 7-offset when reverse is set.
module priority_select_8to3
  import pending_encoder_8to3_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] offset,
  input  logic             reverse,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // NOTE: every combinational output gets a default before the loop so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |req;
    // Scan from the farthest candidate back to the nearest so the nearest hit
    // is the one left standing; the 3-bit add wraps 7 -> 0 for free.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = offset + IDX_W'(k);
      if (reverse) cand = ~cand;
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/pending_encoder_8to3.sv
// Captures request pulses into a pending register and presents them one at a
// time as a 3-bit index under a valid/ack handshake.
module pending_encoder_8to3
  import pending_encoder_8to3_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             E,
  input  logic [N_REQ-1:0] D,
  input  logic             ack,
  output logic [IDX_W-1:0] Y,
  output logic             V,
  output logic [N_REQ-1:0] pending
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] y_q, y_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             accept;
  logic [N_REQ-1:0] set, clr;
  logic [IDX_W-1:0] sel_offset, sel_idx;
  logic             sel_any;

  always_comb begin
    accept    = (state_q == PRESENT) && ack;
    set       = E ? D : '0;
    clr       = accept ? idx_to_onehot(y_q) : '0;
    // Set is OR'ed in after the clear so a re-request during its own ack sticks.
    pending_d = (pending_q & ~clr) | set;
    rr_ptr_d  = accept ? y_q : rr_ptr_q;
    // The scan already sees this cycle's grant, so back-to-back acks rotate.
    sel_offset = ROUND_ROBIN ? IDX_W'(rr_ptr_d + IDX_W'(1)) : '0;
  end

  priority_select_8to3 u_select (
    .req     (pending_d),
    .offset  (sel_offset),
    .reverse (!ROUND_ROBIN),
    .idx     (sel_idx),
    .any     (sel_any)
  );

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    unique case (state_q)
      IDLE: begin
        if (sel_any) begin
          state_d = PRESENT;
          y_d     = sel_idx;
        end
      end
      PRESENT: begin
        if (accept) begin
          if (sel_any) y_d = sel_idx;
          else         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      y_q       <= '0;
      rr_ptr_q  <= IDX_W'(N_REQ - 1);
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      y_q       <= y_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign Y       = y_q;
  assign V       = (state_q == PRESENT);
  assign pending = pending_q;

endmodule
